// File: rtl/dnn_mem_arbiter_if.sv
// rtl/dnn_mem_arbiter_if.sv - Avalon-MM requester port bundle for the SRAM arbiter
interface dnn_mem_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic [AW-1:0]   address;
  logic [DW/8-1:0] byteenable;
  logic            read;
  logic            write;
  logic [DW-1:0]   writedata;
  logic            waitrequest;
  logic [DW-1:0]   readdata;
  logic            readdatavalid;
  logic            err;

  // Requester side drives the command, receives handshake/response
  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid, err
  );

  // Arbiter side receives the command, drives handshake/response
  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid, err
  );
endinterface

// File: rtl/dnn_mem_arbiter.sv
// rtl/dnn_mem_arbiter.sv - round-robin two-port arbiter onto one single-port SRAM
module dnn_mem_arbiter #(
  parameter int AW    = 10,
  parameter int DW    = 32,
  parameter int DEPTH = 800
) (
  input  logic                clk,
  input  logic                rst_n,
  dnn_mem_arbiter_if.slave    p0,
  dnn_mem_arbiter_if.slave    p1,
  input  logic                err_clr,
  output logic [AW-1:0]       mem_address,
  output logic [DW/8-1:0]     mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DW-1:0]       mem_writedata,
  output logic                mem_clken,
  input  logic [DW-1:0]       mem_readdata
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic            prio_q, prio_d;
  logic            rd_pending_q, rd_pending_d;
  logic            rd_port_q, rd_port_d;
  logic            rd_oor_q, rd_oor_d;
  logic            err0_q, err0_d;
  logic            err1_q, err1_d;

  logic            req0, req1, both, gnt_vld, gnt_port;
  logic [AW-1:0]   sel_addr;
  logic [DW/8-1:0] sel_be;
  logic [DW-1:0]   sel_wd;
  logic            sel_wr;
  logic            in_range;
  logic            acc_rd, acc_oor;
  logic [DW-1:0]   rd_data;

  // A write strobe alongside read still counts as a request (write wins later)
  assign req0     = p0.read | p0.write;
  assign req1     = p1.read | p1.write;
  assign both     = req0 & req1;
  assign gnt_vld  = req0 | req1;
  assign gnt_port = both ? prio_q : req1;

  // Winner's command mux and range check
  always_comb begin
    sel_addr = p0.address;
    sel_be   = p0.byteenable;
    sel_wd   = p0.writedata;
    sel_wr   = p0.write;
    if (gnt_port) begin
      sel_addr = p1.address;
      sel_be   = p1.byteenable;
      sel_wd   = p1.writedata;
      sel_wr   = p1.write;
    end
    in_range = ({1'b0, sel_addr} < DEPTH_W);
  end

  // SRAM drive: quiet with no grant, chipselect/write suppressed out of range
  always_comb begin
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    if (gnt_vld) begin
      mem_address    = sel_addr;
      mem_byteenable = sel_be;
      mem_writedata  = sel_wd;
      mem_chipselect = in_range;
      mem_write      = sel_wr & in_range;
    end
  end

  assign mem_clken = 1'b1;

  assign acc_rd  = gnt_vld & ~sel_wr;
  assign acc_oor = gnt_vld & ~in_range;

  // Next-state: pointer moves to the loser only under contention
  always_comb begin
    prio_d       = both ? ~gnt_port : prio_q;
    rd_pending_d = acc_rd;
    rd_port_d    = gnt_port;
    rd_oor_d     = ~in_range;
    err0_d       = (acc_oor & ~gnt_port) | (err0_q & ~err_clr);
    err1_d       = (acc_oor &  gnt_port) | (err1_q & ~err_clr);
  end

  // State registers; reset drops any read in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q       <= 1'b0;
      rd_pending_q <= 1'b0;
      rd_port_q    <= 1'b0;
      rd_oor_q     <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
    end else begin
      prio_q       <= prio_d;
      rd_pending_q <= rd_pending_d;
      rd_port_q    <= rd_port_d;
      rd_oor_q     <= rd_oor_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
    end
  end

  assign rd_data = rd_oor_q ? '0 : mem_readdata;

  assign p0.waitrequest   = ~(gnt_vld & ~gnt_port);
  assign p1.waitrequest   = ~(gnt_vld &  gnt_port);
  assign p0.readdatavalid = rd_pending_q & ~rd_port_q;
  assign p1.readdatavalid = rd_pending_q &  rd_port_q;
  assign p0.readdata      = p0.readdatavalid ? rd_data : '0;
  assign p1.readdata      = p1.readdatavalid ? rd_data : '0;
  assign p0.err           = err0_q;
  assign p1.err           = err1_q;

endmodule

// File: tb/tb_dnn_mem_arbiter.sv
// tb/tb_dnn_mem_arbiter.sv - directed self-checking bench for dnn_mem_arbiter
module tb_dnn_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        err_clr = 1'b0;
  logic [9:0]  mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic        mem_clken;
  logic [31:0] mem_readdata = '0;
  logic [31:0] sram [0:1023];
  int          vec = 0;
  int          bad = 0;

  dnn_mem_arbiter_if #(.AW(10), .DW(32)) p0_if ();
  dnn_mem_arbiter_if #(.AW(10), .DW(32)) p1_if ();

  dnn_mem_arbiter #(.AW(10), .DW(32), .DEPTH(800)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .p0             (p0_if),
    .p1             (p1_if),
    .err_clr        (err_clr),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata)
  );

  always #5 clk = ~clk;

  // SRAM with byte enables and one-cycle read latency
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) sram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= sram[mem_address];
      end
    end
  end

  task idle;
    p0_if.address = '0; p0_if.byteenable = '0; p0_if.read = 0; p0_if.write = 0; p0_if.writedata = '0;
    p1_if.address = '0; p1_if.byteenable = '0; p1_if.read = 0; p1_if.write = 0; p1_if.writedata = '0;
    err_clr = 0;
  endtask

  task next_cycle;
    @(posedge clk);
    #1;
  endtask

  task do_reset;
    rst_n = 0;
    next_cycle();
    rst_n = 1;
  endtask

  task test_reset;
    idle();
    rst_n = 0;
    @(negedge clk);
    vec++; if (p0_if.waitrequest !== 1'b1) begin bad++; $display("FAIL reset_p0_wait got %b exp 1", p0_if.waitrequest); end
    vec++; if (p1_if.waitrequest !== 1'b1) begin bad++; $display("FAIL reset_p1_wait got %b exp 1", p1_if.waitrequest); end
    vec++; if ({p0_if.readdatavalid, p1_if.readdatavalid} !== 2'b00) begin bad++; $display("FAIL reset_rdv got %b exp 00", {p0_if.readdatavalid, p1_if.readdatavalid}); end
    vec++; if ({p0_if.err, p1_if.err} !== 2'b00) begin bad++; $display("FAIL reset_err got %b exp 00", {p0_if.err, p1_if.err}); end
    vec++; if ({mem_chipselect, mem_write, mem_clken} !== 3'b001) begin bad++; $display("FAIL reset_mem got %b exp 001", {mem_chipselect, mem_write, mem_clken}); end
    next_cycle();
    rst_n = 1;
  endtask

  task test_single_read;
    p0_if.read = 1; p0_if.address = 10'd5;
    @(negedge clk);
    vec++; if (p0_if.waitrequest !== 1'b0) begin bad++; $display("FAIL single_p0_wait got %b exp 0", p0_if.waitrequest); end
    vec++; if (p1_if.waitrequest !== 1'b1) begin bad++; $display("FAIL single_p1_wait got %b exp 1", p1_if.waitrequest); end
    vec++; if ({mem_chipselect, mem_write, mem_address} !== {2'b10, 10'd5}) begin bad++; $display("FAIL single_mem got cs=%b we=%b a=%0d exp cs=1 we=0 a=5", mem_chipselect, mem_write, mem_address); end
    next_cycle();
    idle();
    @(negedge clk);
    vec++; if (p0_if.readdatavalid !== 1'b1) begin bad++; $display("FAIL single_rdv got %b exp 1", p0_if.readdatavalid); end
    vec++; if (p0_if.readdata !== 32'h11223344) begin bad++; $display("FAIL single_data got %h exp 11223344", p0_if.readdata); end
    vec++; if ({p1_if.readdatavalid, p1_if.readdata} !== 33'd0) begin bad++; $display("FAIL single_p1_quiet got %b/%h exp 0/0", p1_if.readdatavalid, p1_if.readdata); end
    next_cycle();
  endtask

  task test_contention;
    logic [31:0] exp_d;
    int          prev;
    idle();
    do_reset();
    p0_if.read = 1; p0_if.address = 10'd1;
    p1_if.read = 1; p1_if.address = 10'd2;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vec++; if (p0_if.waitrequest !== ((k % 2) != 0)) begin bad++; $display("FAIL cont_p0_wait[%0d] got %b exp %b", k, p0_if.waitrequest, (k % 2) != 0); end
      vec++; if (p1_if.waitrequest !== ((k % 2) == 0)) begin bad++; $display("FAIL cont_p1_wait[%0d] got %b exp %b", k, p1_if.waitrequest, (k % 2) == 0); end
      if (k > 0) begin
        prev  = (k - 1) % 2;
        exp_d = (prev == 0) ? 32'h00000A01 : 32'h00000B02;
        vec++; if ({p0_if.readdatavalid, p1_if.readdatavalid} !== ((prev == 0) ? 2'b10 : 2'b01)) begin bad++; $display("FAIL cont_rdv[%0d] got %b%b exp port %0d", k, p0_if.readdatavalid, p1_if.readdatavalid, prev); end
        vec++; if ((prev == 0 ? p0_if.readdata : p1_if.readdata) !== exp_d) begin bad++; $display("FAIL cont_data[%0d] got %h exp %h", k, (prev == 0 ? p0_if.readdata : p1_if.readdata), exp_d); end
      end
      next_cycle();
    end
    idle();
    @(negedge clk);
    vec++; if ({p0_if.readdatavalid, p1_if.readdatavalid} !== 2'b01) begin bad++; $display("FAIL cont_last_rdv got %b%b exp 01", p0_if.readdatavalid, p1_if.readdatavalid); end
    vec++; if (p1_if.readdata !== 32'h00000B02) begin bad++; $display("FAIL cont_last_data got %h exp 00000b02", p1_if.readdata); end
    next_cycle();
  endtask

  task test_byteenable;
    idle();
    p1_if.write = 1; p1_if.address = 10'd10; p1_if.writedata = 32'hAABBCCDD; p1_if.byteenable = 4'b0101;
    @(negedge clk);
    vec++; if ({p1_if.waitrequest, mem_chipselect, mem_write, mem_byteenable} !== {3'b011, 4'b0101}) begin bad++; $display("FAIL be_write got wait=%b cs=%b we=%b be=%b exp 0 1 1 0101", p1_if.waitrequest, mem_chipselect, mem_write, mem_byteenable); end
    next_cycle();
    idle();
    p0_if.read = 1; p0_if.address = 10'd10;
    @(negedge clk);
    vec++; if ({p0_if.readdatavalid, p1_if.readdatavalid} !== 2'b00) begin bad++; $display("FAIL be_write_rdv got %b%b exp 00", p0_if.readdatavalid, p1_if.readdatavalid); end
    next_cycle();
    idle();
    @(negedge clk);
    vec++; if (p0_if.readdata !== 32'h00BB00DD) begin bad++; $display("FAIL be_read_data got %h exp 00bb00dd", p0_if.readdata); end
    next_cycle();
  endtask

  task test_out_of_range;
    idle();
    p0_if.write = 1; p0_if.address = 10'd800; p0_if.writedata = 32'hDEADBEEF; p0_if.byteenable = 4'hF;
    @(negedge clk);
    vec++; if ({p0_if.waitrequest, mem_chipselect, mem_write} !== 3'b000) begin bad++; $display("FAIL oor_write got wait=%b cs=%b we=%b exp 000", p0_if.waitrequest, mem_chipselect, mem_write); end
    next_cycle();
    idle();
    p0_if.read = 1; p0_if.address = 10'd1023;
    @(negedge clk);
    vec++; if (mem_chipselect !== 1'b0) begin bad++; $display("FAIL oor_read_cs got %b exp 0", mem_chipselect); end
    vec++; if ({p0_if.err, p1_if.err} !== 2'b10) begin bad++; $display("FAIL oor_err_set got %b%b exp 10", p0_if.err, p1_if.err); end
    next_cycle();
    idle();
    @(negedge clk);
    vec++; if ({p0_if.readdatavalid, p0_if.readdata} !== {1'b1, 32'h0}) begin bad++; $display("FAIL oor_read_ret got %b/%h exp 1/00000000", p0_if.readdatavalid, p0_if.readdata); end
    next_cycle();
    @(negedge clk);
    vec++; if ({p0_if.err, p1_if.err} !== 2'b10) begin bad++; $display("FAIL oor_err_sticky got %b%b exp 10", p0_if.err, p1_if.err); end
    err_clr = 1;
    next_cycle();
    err_clr = 0;
    @(negedge clk);
    vec++; if ({p0_if.err, p1_if.err} !== 2'b00) begin bad++; $display("FAIL oor_err_clr got %b%b exp 00", p0_if.err, p1_if.err); end
    p1_if.write = 1; p1_if.address = 10'd900; p1_if.byteenable = 4'hF;
    err_clr = 1;
    next_cycle();
    idle();
    @(negedge clk);
    vec++; if ({p0_if.err, p1_if.err} !== 2'b01) begin bad++; $display("FAIL oor_set_wins got %b%b exp 01", p0_if.err, p1_if.err); end
    err_clr = 1;
    next_cycle();
    err_clr = 0;
  endtask

  task test_reset_mid_read;
    idle();
    do_reset();
    p0_if.read = 1; p0_if.address = 10'd1;
    p1_if.read = 1; p1_if.address = 10'd2;
    @(negedge clk);
    vec++; if (p0_if.waitrequest !== 1'b0) begin bad++; $display("FAIL rmr_first_grant got %b exp 0", p0_if.waitrequest); end
    next_cycle();
    p0_if.read = 0;
    @(negedge clk);
    vec++; if (p1_if.waitrequest !== 1'b0) begin bad++; $display("FAIL rmr_p1_grant got %b exp 0", p1_if.waitrequest); end
    #1 rst_n = 0;
    next_cycle();
    p0_if.read = 1;
    @(negedge clk);
    vec++; if ({p0_if.readdatavalid, p1_if.readdatavalid} !== 2'b00) begin bad++; $display("FAIL rmr_no_rdv got %b%b exp 00", p0_if.readdatavalid, p1_if.readdatavalid); end
    vec++; if ({p0_if.waitrequest, p1_if.waitrequest} !== 2'b01) begin bad++; $display("FAIL rmr_prio_in_reset got %b%b exp 01", p0_if.waitrequest, p1_if.waitrequest); end
    next_cycle();
    rst_n = 1;
    @(negedge clk);
    vec++; if ({p0_if.waitrequest, p1_if.waitrequest} !== 2'b01) begin bad++; $display("FAIL rmr_prio_after got %b%b exp 01", p0_if.waitrequest, p1_if.waitrequest); end
    vec++; if (p1_if.readdatavalid !== 1'b0) begin bad++; $display("FAIL rmr_p1_rdv got %b exp 0", p1_if.readdatavalid); end
    next_cycle();
    idle();
    @(negedge clk);
    vec++; if ({p0_if.readdatavalid, p0_if.readdata} !== {1'b1, 32'h00000A01}) begin bad++; $display("FAIL rmr_p0_ret got %b/%h exp 1/00000a01", p0_if.readdatavalid, p0_if.readdata); end
    next_cycle();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) sram[i] = '0;
    sram[1] = 32'h00000A01;
    sram[2] = 32'h00000B02;
    sram[5] = 32'h11223344;
    test_reset();
    test_single_read();
    test_contention();
    test_byteenable();
    test_out_of_range();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule

// File: doc/dnn_mem_arbiter.md
Name: dnn_mem_arbiter

Overview:
- Shares one single-port on-chip SRAM (32-bit words, byte enables, 1-cycle read latency) between two Avalon-MM requesters.
- Port 0 is the DNN accelerator master; port 1 is the CPU data master.
- Round-robin arbitration with per-port waitrequest and readdatavalid.
- Out-of-range accesses are blocked and flagged.
- Sits between both masters and the SRAM's s1 slave.

Parameters:
- AW, 10, word-address width.
- DW, 32, data width; byte-enable width is DW/8.
- DEPTH, 800, number of implemented words; addresses >= DEPTH are out of range.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- pN_address  in  AW  word address (N = 0, 1).
- pN_byteenable  in  DW/8  byte lanes for writes.
- pN_read  in  1  read request.
- pN_write  in  1  write request.
- pN_writedata  in  DW  write data.
- pN_waitrequest  out  1  high = request not accepted this cycle.
- pN_readdata  out  DW  read data.
- pN_readdatavalid  out  1  one-cycle pulse qualifying pN_readdata.
- pN_err  out  1  sticky flag: port issued an out-of-range access.
- err_clr  in  1  clears both pN_err.
- mem_address  out  AW  to SRAM.
- mem_byteenable  out  DW/8  to SRAM.
- mem_chipselect  out  1  to SRAM.
- mem_write  out  1  to SRAM.
- mem_writedata  out  DW  to SRAM.
- mem_clken  out  1  to SRAM; tied to 1.
- mem_readdata  in  DW  from SRAM; valid the cycle after the address edge.

Behaviour:
- Request and arbitration
  - reqN = pN_read | pN_write. If both are asserted, write wins and the access is treated as a write.
  - Arbitration is combinational in the current cycle.
  - Only one requester: it wins.
  - Both requesting: the winner is the port indicated by the registered pointer prio (0 or 1).
  - prio toggles to the loser on every cycle where both requested and a grant issued. It is unchanged otherwise.
- Granted port
  - pN_waitrequest = 0 for the winner.
  - pN_waitrequest = 1 for the loser and for any idle port.
  - The address, byteenable, writedata and the write bit of the winner are muxed onto mem_*.
  - mem_chipselect = 1 if the winner is in range (address < DEPTH), else 0. Out of range, mem_write is also forced to 0.
  - No grant: mem_chipselect = 0, mem_write = 0, other mem_* = 0.
- Read return, fixed 1-cycle latency
  - Registered tag {rd_pending, rd_port, rd_oor} is set at the edge that accepts a read.
  - On the next cycle, p[rd_port]_readdatavalid = 1.
  - p[rd_port]_readdata = rd_oor ? 0 : mem_readdata. The other port's readdata = 0.
  - Reads are fully pipelined: back-to-back grants yield back-to-back readdatavalid pulses, in grant order.
- Writes produce no readdatavalid.
- Errors
  - pN_err sets at the edge accepting an out-of-range access from port N.
  - err_clr clears both flags. If set and clear fall on the same edge, set wins.
- Reset (async, rst_n = 0)
  - prio = 0, rd_pending = 0, pN_err = 0.
  - All readdatavalid = 0. All waitrequest follow the combinational rule, so idle ports read 1.
  - A read granted in the cycle reset asserts returns no data.

Test Plan:
- Single read
  - Stimulus: p0 reads addr 5 (preloaded 0x11223344).
  - Response: p0_waitrequest=0 that cycle; next cycle p0_readdatavalid=1, p0_readdata=0x11223344; p1 outputs quiet.
- Contention
  - Stimulus: p0 and p1 both hold read requests for 4 cycles from reset.
  - Response: grants alternate p0, p1, p0, p1; each port sees waitrequest=1 on the opposite cycles; each readdatavalid lands on the correct port one cycle later.
- Byte-enable write then read
  - Stimulus: p1 writes 0xAABBCCDD with byteenable 4'b0101 to addr 10 (previously 0); p0 then reads addr 10.
  - Response: p0_readdata = 0x00BB00DD.
- Out of range
  - Stimulus: p0 writes addr 800, then reads addr 1023.
  - Response: mem_chipselect=0 on both cycles; the read returns 0 with readdatavalid; p0_err=1 and stays 1 until err_clr; p1_err=0.
- Reset mid-read
  - Stimulus: assert rst_n=0 in the same cycle a p1 read is granted.
  - Response: p1_readdatavalid stays 0; prio=0; after release, a simultaneous request grants p0 first.
